fire_sequencer: RTL and testbench
=================================

# fire_sequencer

Clocked sequencer that generates the `evaluateFire`, `complementFire` and `resetFire` events consumed by the evaluate/complement flag latches in the FaSATer datapath. For each variable index it:
- fires an evaluation,
- waits for the evaluation result handshake,
- conditionally fires a complement (variable flip),
- fires a reset to clear both flags.

It iterates over all variables for a bounded number of rounds and reports satisfied, exhausted or timed-out status to the top-level controller.

## Interface
Parameters:
- `VAR_W`, 8: width of the variable index and `numVars`.
- `ROUND_W`, 8: width of the round counter and `maxRounds`.
- `PULSE_W`, 2: width in clock cycles of every fire pulse (≥1).
- `WAIT_MAX`, 255: maximum `EVAL_WAIT` cycles before timeout (≥1).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `numVars` in VAR_W: number of variables; captured at start.
- `maxRounds` in ROUND_W: round limit, 0 = unlimited; captured at start.
- `evalDone` in 1: evaluation-complete level; sampled only in EVAL_WAIT.
- `satisfied` in 1: formula satisfied; sampled with `evalDone`.
- `flip` in 1: complement the current variable; sampled with `evalDone`.
- `evaluateFire` out 1: evaluation fire pulse.
- `complementFire` out 1: complement fire pulse.
- `resetFire` out 1: flag-clear fire pulse.
- `varIndex` out VAR_W: current variable index.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `sat` out 1: run ended satisfied; held until next accepted start.
- `timeout` out 1: run ended on `WAIT_MAX` expiry; held until next accepted start.

## Operation
- **Reset:** state IDLE. All outputs 0, including `varIndex`. Counters cleared. `rst` overrides every state, including mid-pulse: all fire outputs drop the cycle after `rst` is sampled.
- **States:** IDLE, EVAL_FIRE, EVAL_GAP, EVAL_WAIT, COMP_FIRE, COMP_GAP, RESET_FIRE, RESET_GAP, NEXT, FINISH.
- **IDLE:** on `start`, capture `numVars`/`maxRounds`, clear `sat`, `timeout`, `varIndex` and the round counter.
  - `numVars`=0: go to FINISH (`sat`=0).
  - Otherwise: go to EVAL_FIRE.
- **EVAL_FIRE:** `evaluateFire`=1 for PULSE_W cycles, then EVAL_GAP (1 cycle, all fires low).
- **EVAL_WAIT:** wait counter runs from 1.
  - **`evalDone`=1 and `satisfied`=1:** set `sat`, then RESET_FIRE, then FINISH.
  - **Else `evalDone`=1 and `flip`=1:** COMP_FIRE.
  - **Else `evalDone`=1:** RESET_FIRE.
  - **Priority:** `satisfied` over `flip`.
  - **Timeout:** if the counter reaches WAIT_MAX without `evalDone`, set `timeout`, then RESET_FIRE, then FINISH.
- **COMP_FIRE:** `complementFire`=1 for PULSE_W cycles, then COMP_GAP (1 cycle).
- **RESET_FIRE:** `resetFire`=1 for PULSE_W cycles, then RESET_GAP (1 cycle). Then FINISH if `sat` or `timeout` is set, else NEXT.
- **NEXT (1 cycle):**
  - If `varIndex` = numVars−1: `varIndex`←0 and round++. If `maxRounds`≠0 and round reaches `maxRounds`, go to FINISH (`sat`=0).
  - Otherwise: `varIndex`++.
  - Then EVAL_FIRE.
- **FINISH:** `done`=1 for 1 cycle, then IDLE. `varIndex` holds its last value.
- **Pulse rules:**
  - At most one fire output is high in any cycle.
  - At least one all-low cycle separates any two fire pulses.
  - Every pulse is exactly PULSE_W cycles.
- **Counters:** `varIndex` and round are unsigned and never exceed the captured limits. The round counter saturates when `maxRounds`=0.
- **Ignored inputs:**
  - `start` while busy.
  - `evalDone`, `flip` and `satisfied` outside EVAL_WAIT.

## Timing
- `start` sampled at cycle 0: `busy`=1 and `evaluateFire`=1 from cycle 1.
- With `evalDone` already high on entry to EVAL_WAIT:
  - non-flip variable: 2·PULSE_W+4 cycles;
  - flip variable: 3·PULSE_W+5 cycles.
- Each additional EVAL_WAIT cycle adds 1.
- `done` asserts the cycle after the final RESET_GAP or NEXT cycle. `sat`/`timeout` are valid in the same cycle as `done`.
- Back-to-back runs: `start` is accepted in IDLE the cycle after `done`.

## Test plan
- **Exhausted run:** PULSE_W=2, `numVars`=3, `maxRounds`=2, `evalDone`=1 constant, `flip`=0, `satisfied`=0, start at cycle 0 -> 6 `evaluateFire` and 6 `resetFire` pulses, 0 `complementFire`; `varIndex` sequence 0,1,2,0,1,2; `done` at cycle 49; `sat`=0, `timeout`=0.
- **Flip path:** same setup with `numVars`=2, `maxRounds`=1, `flip`=1 on variable 1 only -> per-variable durations 8 and 11 cycles; one `complementFire` pulse between the 2nd evaluate and the 2nd reset; `done` at cycle 20.
- **Satisfied mid-round:** `satisfied`=1 with `evalDone` on variable 2 of 5 -> one `resetFire`, then `done`; `sat`=1; `varIndex`=2; no further `evaluateFire`.
- **Timeout:** WAIT_MAX=4, `evalDone` held 0 -> `timeout`=1 after 4 EVAL_WAIT cycles, then one `resetFire` pulse, then `done`; `sat`=0.
- **Reset mid-pulse:** `rst` asserted during the 2nd cycle of COMP_FIRE -> all outputs 0 the next cycle, state IDLE; a later `start` runs normally from `varIndex` 0.
- **Edge cases:** `numVars`=0 start -> `done` the next cycle, `sat`=0, no fire pulses; `start` while busy -> ignored, sequence unchanged; a check that no two fire outputs are ever high together and an all-low gap always separates pulses.

Source files
------------

// File: rtl/fire_sequencer.sv
// Sequencer driving the evaluate/complement/reset fire pulses of the flag latches.
// Walks every variable index for a bounded number of rounds and reports the outcome.
module fire_sequencer #(
  parameter int VAR_W    = 8,
  parameter int ROUND_W  = 8,
  parameter int PULSE_W  = 2,
  parameter int WAIT_MAX = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VAR_W-1:0]   numVars,
  input  logic [ROUND_W-1:0] maxRounds,
  input  logic               evalDone,
  input  logic               satisfied,
  input  logic               flip,
  output logic               evaluateFire,
  output logic               complementFire,
  output logic               resetFire,
  output logic [VAR_W-1:0]   varIndex,
  output logic               busy,
  output logic               done,
  output logic               sat,
  output logic               timeout
);

  localparam int PCNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_W - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(WAIT_MAX);

  typedef enum logic [3:0] {
    IDLE, EVAL_FIRE, EVAL_GAP, EVAL_WAIT, COMP_FIRE,
    COMP_GAP, RESET_FIRE, RESET_GAP, NEXT, FINISH
  } state_t;

  state_t             state_reg, state_next;
  logic [PCNT_W-1:0]  pulse_cnt_reg, pulse_cnt_next;
  logic [WCNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [VAR_W-1:0]   var_idx_reg, var_idx_next;
  logic [VAR_W-1:0]   num_vars_reg, num_vars_next;
  logic [ROUND_W-1:0] round_reg, round_next;
  logic [ROUND_W-1:0] max_rounds_reg, max_rounds_next;
  logic               sat_reg, sat_next;
  logic               timeout_reg, timeout_next;
  logic               pulse_last;
  logic [ROUND_W-1:0] round_inc;

  assign pulse_last = (pulse_cnt_reg == PULSE_LAST);
  assign round_inc  = round_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pulse_cnt_reg  <= '0;
      wait_cnt_reg   <= '0;
      var_idx_reg    <= '0;
      num_vars_reg   <= '0;
      round_reg      <= '0;
      max_rounds_reg <= '0;
      sat_reg        <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pulse_cnt_reg  <= pulse_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      var_idx_reg    <= var_idx_next;
      num_vars_reg   <= num_vars_next;
      round_reg      <= round_next;
      max_rounds_reg <= max_rounds_next;
      sat_reg        <= sat_next;
      timeout_reg    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pulse_cnt_next  = pulse_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    var_idx_next    = var_idx_reg;
    num_vars_next   = num_vars_reg;
    round_next      = round_reg;
    max_rounds_next = max_rounds_reg;
    sat_next        = sat_reg;
    timeout_next    = timeout_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          num_vars_next   = numVars;
          max_rounds_next = maxRounds;
          sat_next        = 1'b0;
          timeout_next    = 1'b0;
          var_idx_next    = '0;
          round_next      = '0;
          pulse_cnt_next  = '0;
          state_next      = (numVars == '0) ? FINISH : EVAL_FIRE;
        end
      end
      EVAL_FIRE: begin
        pulse_cnt_next = pulse_last ? '0 : pulse_cnt_reg + 1'b1;
        if (pulse_last) state_next = EVAL_GAP;
      end
      EVAL_GAP: begin
        wait_cnt_next = WCNT_W'(1);
        state_next    = EVAL_WAIT;
      end
      EVAL_WAIT: begin
        // satisfied outranks flip; both only count alongside evalDone
        if (evalDone) begin
          if (satisfied) begin
            sat_next   = 1'b1;
            state_next = RESET_FIRE;
          end else if (flip) begin
            state_next = COMP_FIRE;
          end else begin
            state_next = RESET_FIRE;
          end
        end else if (wait_cnt_reg == WAIT_LAST) begin
          timeout_next = 1'b1;
          state_next   = RESET_FIRE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      COMP_FIRE: begin
        pulse_cnt_next = pulse_last ? '0 : pulse_cnt_reg + 1'b1;
        if (pulse_last) state_next = COMP_GAP;
      end
      COMP_GAP:   state_next = RESET_FIRE;
      RESET_FIRE: begin
        pulse_cnt_next = pulse_last ? '0 : pulse_cnt_reg + 1'b1;
        if (pulse_last) state_next = RESET_GAP;
      end
      RESET_GAP:  state_next = (sat_reg || timeout_reg) ? FINISH : NEXT;
      NEXT: begin
        state_next = EVAL_FIRE;
        if (var_idx_reg == num_vars_reg - 1'b1) begin
          var_idx_next = '0;
          // an unlimited run parks the round counter at its maximum
          if (max_rounds_reg == '0) begin
            round_next = (&round_reg) ? round_reg : round_inc;
          end else begin
            round_next = round_inc;
            if (round_inc == max_rounds_reg) state_next = FINISH;
          end
        end else begin
          var_idx_next = var_idx_reg + 1'b1;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign evaluateFire   = (state_reg == EVAL_FIRE);
  assign complementFire = (state_reg == COMP_FIRE);
  assign resetFire      = (state_reg == RESET_FIRE);
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == FINISH);
  assign varIndex       = var_idx_reg;
  assign sat            = sat_reg;
  assign timeout        = timeout_reg;

endmodule

// File: tb/tb_fire_sequencer.sv
// Scoreboard bench for fire_sequencer: a timing model queues the expected pulse/done events,
// a monitor pops and checks them as the DUT emits them, alongside pulse-shape rules.
module tb_fire_sequencer;

  localparam int P  = 2;
  localparam int WM = 4;
  localparam int K_EVAL = 0, K_COMP = 1, K_RST = 2, K_DONE = 3;

  logic       clk, rst, start, evalDone, satisfied, flip;
  logic [7:0] numVars, maxRounds, varIndex;
  logic       evaluateFire, complementFire, resetFire, busy, done, sat, timeout;

  typedef struct {
    int kind;
    int vidx;
    int cyc;
    int s;
    int to;
  } ev_t;

  ev_t        exp_q[$];
  int         n_tests = 0, n_fail = 0;
  int         cyc = 0, start_cyc = 0;
  logic [7:0] flip_mask = 8'd0;
  bit         sat_en = 0;
  int         sat_var = 0;
  int         exp_sat = 0, exp_to = 0;

  fire_sequencer #(.VAR_W(8), .ROUND_W(8), .PULSE_W(P), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .start(start), .numVars(numVars), .maxRounds(maxRounds),
    .evalDone(evalDone), .satisfied(satisfied), .flip(flip),
    .evaluateFire(evaluateFire), .complementFire(complementFire), .resetFire(resetFire),
    .varIndex(varIndex), .busy(busy), .done(done), .sat(sat), .timeout(timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int v, input int t, input int s, input int to);
    ev_t e;
    e.kind = kind; e.vidx = v; e.cyc = t; e.s = s; e.to = to;
    exp_q.push_back(e);
  endtask

  // Expected event timeline, counted in cycles after the cycle start is sampled
  task automatic model(input int n, input int maxr, input bit ed, input logic [7:0] fm,
                       input bit se, input int sv);
    int t, v, rnd;
    t = 1; v = 0; rnd = 0;
    exp_sat = 0; exp_to = 0;
    if (n == 0) begin
      push_ev(K_DONE, 0, 1, 0, 0);
      return;
    end
    for (int k = 0; k < 1000; k++) begin
      push_ev(K_EVAL, v, t, 0, 0);
      t += P + 1;
      t += ed ? 1 : WM;
      if (!ed || (se && v == sv)) begin
        push_ev(K_RST, v, t, 0, 0);
        t += P + 1;
        exp_sat = ed ? 1 : 0;
        exp_to  = ed ? 0 : 1;
        push_ev(K_DONE, v, t, exp_sat, exp_to);
        return;
      end
      if (fm[v]) begin
        push_ev(K_COMP, v, t, 0, 0);
        t += P + 1;
      end
      push_ev(K_RST, v, t, 0, 0);
      t += P + 1;
      t += 1;
      if (v == n - 1) begin
        v = 0;
        rnd++;
        if (maxr != 0 && rnd == maxr) begin
          push_ev(K_DONE, 0, t, 0, 0);
          return;
        end
      end else begin
        v++;
      end
    end
  endtask

  // Reactive stimulus: flip/satisfied follow the current variable
  always @(negedge clk) begin
    flip      = flip_mask[varIndex[2:0]];
    satisfied = sat_en && (int'(varIndex) == sat_var);
  end

  task automatic pop_cmp(input int kind, input int rel);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check_eq("event_kind", kind, e.kind);
      check_eq("event_var", int'(varIndex), e.vidx);
      check_eq("event_cycle", rel, e.cyc);
      if (kind == K_DONE) begin
        check_eq("done_sat", int'(sat), e.s);
        check_eq("done_timeout", int'(timeout), e.to);
      end
    end
  endtask

  logic [2:0] prev_fv = 3'b000;
  int         plen[3];

  always @(posedge clk) begin
    logic [2:0] fv;
    int rel;
    cyc = cyc + 1;
    #1;
    fv  = {resetFire, complementFire, evaluateFire};
    rel = cyc - start_cyc + 1;
    check_eq("onehot_fire", ($countones(fv) <= 1) ? 1 : 0, 1);
    for (int i = 0; i < 3; i++) begin
      if (fv[i] && !prev_fv[i]) begin
        check_eq("gap_before_pulse", int'(prev_fv), 0);
        pop_cmp(i, rel);
        plen[i] = 1;
      end else if (fv[i]) begin
        plen[i]++;
      end else if (prev_fv[i] && !rst) begin
        check_eq("pulse_width", plen[i], P);
      end
    end
    if (done) pop_cmp(K_DONE, rel);
    prev_fv = fv;
  end

  task automatic run(input int n, input int maxr, input bit ed, input logic [7:0] fm,
                     input bit se, input int sv, input bit poke);
    @(negedge clk);
    numVars   = 8'(n);
    maxRounds = 8'(maxr);
    evalDone  = ed;
    flip_mask = fm;
    sat_en    = se;
    sat_var   = sv;
    model(n, maxr, ed, fm, se, sv);
    start     = 1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 0;
    for (int i = 2; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      if (poke && i == 10) begin
        start   = 1;
        numVars = 8'd0;
      end
      if (poke && i == 11) begin
        start   = 0;
        numVars = 8'(n);
      end
    end
    if (exp_q.size() != 0) begin
      check_eq("run_budget_left", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
    check_eq("idle_done_low", int'(done), 0);
    check_eq("idle_busy_low", int'(busy), 0);
    check_eq("held_sat", int'(sat), exp_sat);
    check_eq("held_timeout", int'(timeout), exp_to);
  endtask

  initial begin
    rst = 1; start = 0; numVars = 0; maxRounds = 0;
    evalDone = 0; satisfied = 0; flip = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             int'({evaluateFire, complementFire, resetFire, busy, done, sat, timeout, varIndex}), 0);
    rst = 0;

    run(3, 2, 1'b1, 8'h00, 1'b0, 0, 1'b1);  // exhausted run, start poked while busy
    run(2, 1, 1'b1, 8'h02, 1'b0, 0, 1'b0);  // flip on variable 1
    run(5, 1, 1'b1, 8'h00, 1'b1, 2, 1'b0);  // satisfied on variable 2
    run(3, 0, 1'b0, 8'h00, 1'b0, 0, 1'b0);  // evaluation never completes
    run(0, 3, 1'b1, 8'h00, 1'b0, 0, 1'b0);  // empty formula

    // Reset during the second cycle of the complement pulse
    @(negedge clk);
    numVars = 8'd2; maxRounds = 8'd1; evalDone = 1; flip_mask = 8'h02; sat_en = 0;
    model(2, 1, 1'b1, 8'h02, 1'b0, 0);
    start = 1;
    start_cyc = cyc + 1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) start = 0;
    end
    check_eq("comp_before_rst", int'(complementFire), 1);
    rst = 1;
    @(negedge clk);
    check_eq("rst_midpulse_outputs",
             int'({evaluateFire, complementFire, resetFire, busy, done, sat, timeout, varIndex}), 0);
    check_eq("rst_events_left", exp_q.size(), 2);
    exp_q.delete();
    rst = 0;

    run(2, 1, 1'b1, 8'h02, 1'b0, 0, 1'b0);  // normal run after the reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
